// File: rtl/neighbor_stream_rx.sv
// Neighbor-stream receiver: frames packed ID words, buffers them, unpacks to IDs.
// Define NEIGHBOR_RX_TAG_FILTER_EN to accept only words tagged MY_TAG.
module neighbor_stream_rx #(
  parameter int ID_W       = 7,
  parameter int NUM_W      = 5,
  parameter int TAG_W      = 2,
  parameter int MY_TAG     = 0,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          In_valid,
  input  logic                          In_sos,
  input  logic                          In_eos,
  input  logic [2*ID_W-1:0]             In_data,
  input  logic [TAG_W-1:0]              In_PE_tag,
  input  logic [NUM_W-1:0]              In_num_Iter,
  input  logic                          Nb_ready,
  output logic                          Nb_valid,
  output logic [ID_W-1:0]               Nb_id,
  output logic                          Nb_first,
  output logic                          Nb_last,
  output logic                          Pkt_done,
  output logic                          Busy,
  output logic                          Proto_err,
  output logic                          Ovf_err,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state_q, state_d;
  logic [NUM_W-1:0] n_q, n_d;
  logic [NUM_W-1:0] wc_q, wc_d;
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             h_q, h_d;
  logic             perr_q, perr_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [2*ID_W-1:0] mem_data_q  [FIFO_DEPTH];
  logic              mem_first_q [FIFO_DEPTH];
  logic              mem_last_q  [FIFO_DEPTH];
  logic              mem_sl_q    [FIFO_DEPTH];

  logic elig;
`ifdef NEIGHBOR_RX_TAG_FILTER_EN
  assign elig = In_valid & (In_PE_tag == TAG_W'(MY_TAG));
`else
  logic unused_tag;
  assign unused_tag = ^{In_PE_tag, TAG_W'(MY_TAG)};
  assign elig = In_valid;
`endif

  logic [2*ID_W-1:0] hd_data;
  logic hd_first, hd_last, hd_sl;
  logic valid, full, xfer, pop;

  assign hd_data  = mem_data_q[rp_q];
  assign hd_first = mem_first_q[rp_q];
  assign hd_last  = mem_last_q[rp_q];
  assign hd_sl    = mem_sl_q[rp_q];

  assign valid = (cnt_q != '0);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign xfer  = valid & Nb_ready;
  assign pop   = xfer & (h_q | hd_sl);

  assign Nb_valid  = valid;
  assign Nb_id     = !valid ? '0 :
                     h_q ? hd_data[2*ID_W-1:ID_W] : hd_data[ID_W-1:0];
  assign Nb_first  = valid & hd_first & ~h_q;
  assign Nb_last   = valid & hd_last & (h_q | hd_sl);
  assign Pkt_done  = done_q;
  assign Busy      = (state_q == RECV) | valid | h_q;
  assign Proto_err = perr_q;
  assign Ovf_err   = ovf_q;
  assign Fifo_cnt  = cnt_q;

  // W = ceil(N/2), widened so the maximum N cannot wrap
  logic [NUM_W:0] w_cur, wc_inc;
  assign w_cur  = ({1'b0, n_q} + (NUM_W+1)'(1)) >> 1;
  assign wc_inc = {1'b0, wc_q} + (NUM_W+1)'(1);

  logic push, wr_en, mark_req, mark_en;
  logic e_first, e_last, e_sl, end_word, n0_done;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    wc_d     = wc_q;
    perr_d   = perr_q;
    ovf_d    = ovf_q;
    push     = 1'b0;
    mark_req = 1'b0;
    e_first  = 1'b0;
    e_last   = 1'b0;
    e_sl     = 1'b0;
    end_word = 1'b0;
    n0_done  = 1'b0;
    if (elig) begin
      if (In_sos) begin
        if (state_q == RECV) begin
          perr_d   = 1'b1;
          mark_req = 1'b1;
        end
        n_d     = In_num_Iter;
        wc_d    = NUM_W'(1);
        e_first = 1'b1;
        if (In_eos) begin
          state_d = IDLE;
          if (In_num_Iter == '0) begin
            n0_done = 1'b1;
          end else begin
            push   = 1'b1;
            e_last = 1'b1;
            e_sl   = (In_num_Iter == NUM_W'(1));
            if (In_num_Iter > NUM_W'(2)) perr_d = 1'b1;
          end
        end else begin
          push    = 1'b1;
          state_d = RECV;
        end
      end else if (state_q == IDLE) begin
        perr_d = 1'b1;
      end else begin
        push = 1'b1;
        wc_d = wc_q + NUM_W'(1);
        if (In_eos) begin
          e_last   = 1'b1;
          end_word = 1'b1;
          e_sl     = n_q[0] & (wc_inc == w_cur);
          if (wc_inc != w_cur) perr_d = 1'b1;
          state_d  = IDLE;
        end else if (wc_inc >= w_cur) begin
          perr_d   = 1'b1;
          e_last   = 1'b1;
          end_word = 1'b1;
          state_d  = IDLE;
        end
      end
    end
    wr_en = push & (~full | pop);
    // a dropped closing word still closes the packet on the stored tail
    if (push & ~wr_en) begin
      ovf_d = 1'b1;
      if (end_word) mark_req = 1'b1;
    end
    mark_en = mark_req & (cnt_q > CW'(pop));
  end

  assign wp_d    = wr_en ? wp_q + AW'(1) : wp_q;
  assign rp_d    = pop ? rp_q + AW'(1) : rp_q;
  assign cnt_d   = cnt_q + CW'(wr_en) - CW'(pop);
  assign h_d     = xfer ? ~pop : h_q;
  assign done_d  = (xfer & Nb_last) | n0_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      wc_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      h_q     <= 1'b0;
      perr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wc_q    <= wc_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      perr_q  <= perr_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data_q[wp_q]  <= In_data;
      mem_first_q[wp_q] <= e_first;
      mem_last_q[wp_q]  <= e_last;
      mem_sl_q[wp_q]    <= e_sl;
    end
    if (mark_en) begin
      mem_last_q[wp_q - AW'(1)] <= 1'b1;
      mem_sl_q[wp_q - AW'(1)]   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neighbor_stream_rx.sv
// Directed bench for neighbor_stream_rx: framing, unpacking, overflow, reset.
// Tag-filter expectations follow NEIGHBOR_RX_TAG_FILTER_EN.
module tb_neighbor_stream_rx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        In_valid = 1'b0;
  logic        In_sos = 1'b0;
  logic        In_eos = 1'b0;
  logic [13:0] In_data = '0;
  logic [1:0]  In_PE_tag = '0;
  logic [4:0]  In_num_Iter = '0;
  logic        Nb_ready = 1'b0;
  logic        Nb_valid, Nb_first, Nb_last, Pkt_done, Busy;
  logic        Proto_err, Ovf_err;
  logic [6:0]  Nb_id;
  logic [3:0]  Fifo_cnt;

  int checks = 0;
  int errors = 0;
  logic [8:0] mon_q[$];
  int done_cnt = 0;

  neighbor_stream_rx #(.MY_TAG(2)) dut (
    .clk(clk), .reset(reset),
    .In_valid(In_valid), .In_sos(In_sos), .In_eos(In_eos),
    .In_data(In_data), .In_PE_tag(In_PE_tag), .In_num_Iter(In_num_Iter),
    .Nb_ready(Nb_ready), .Nb_valid(Nb_valid), .Nb_id(Nb_id),
    .Nb_first(Nb_first), .Nb_last(Nb_last), .Pkt_done(Pkt_done),
    .Busy(Busy), .Proto_err(Proto_err), .Ovf_err(Ovf_err),
    .Fifo_cnt(Fifo_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Nb_valid && Nb_ready) mon_q.push_back({Nb_id, Nb_first, Nb_last});
    if (Pkt_done) done_cnt++;
  end

  task automatic put(input logic s, input logic e, input logic [6:0] lo,
                     input logic [6:0] hi, input logic [4:0] n,
                     input logic [1:0] tag);
    @(posedge clk); #1;
    In_valid = 1'b1; In_sos = s; In_eos = e;
    In_data = {hi, lo}; In_num_Iter = n; In_PE_tag = tag;
  endtask

  task automatic idle_in();
    @(posedge clk); #1;
    In_valid = 1'b0; In_sos = 1'b0; In_eos = 1'b0;
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({Nb_valid, Nb_id, Nb_first, Nb_last, Pkt_done, Busy, Proto_err,
         Ovf_err, Fifo_cnt} !== 18'd0) begin
      errors++; $display("FAIL reset_hold: got %h want 0", {Nb_valid, Nb_id,
        Nb_first, Nb_last, Pkt_done, Busy, Proto_err, Ovf_err, Fifo_cnt});
    end
    reset = 1'b0;
    cycles(1);
    checks++;
    if ({Nb_valid, Busy, Proto_err, Ovf_err, Fifo_cnt} !== 8'd0) begin
      errors++; $display("FAIL reset_idle: got %h want 0",
        {Nb_valid, Busy, Proto_err, Ovf_err, Fifo_cnt});
    end
  endtask

  task automatic test_n2();
    int lb, db;
    lb = mon_q.size(); db = done_cnt;
    Nb_ready = 1'b0;
    put(1, 1, 7'h05, 7'h15, 5'd2, 2'd0);
    idle_in();
    checks++;
    if ({Nb_valid, Nb_id, Nb_first, Nb_last, Fifo_cnt} !== {1'b1, 7'h05, 2'b10, 4'd1}) begin
      errors++; $display("FAIL n2_head: got %h want %h",
        {Nb_valid, Nb_id, Nb_first, Nb_last, Fifo_cnt}, {1'b1, 7'h05, 2'b10, 4'd1});
    end
    cycles(1);
    checks++;
    if ({Nb_valid, Nb_id, Nb_first, Nb_last} !== {1'b1, 7'h05, 2'b10}) begin
      errors++; $display("FAIL n2_hold: got %h want %h",
        {Nb_valid, Nb_id, Nb_first, Nb_last}, {1'b1, 7'h05, 2'b10});
    end
    Nb_ready = 1'b1;
    cycles(4);
    checks++;
    if (mon_q.size() - lb !== 2) begin
      errors++; $display("FAIL n2_count: got %0d want 2", mon_q.size() - lb);
    end
    checks++;
    if (mon_q[lb] !== {7'h05, 2'b10} || mon_q[lb+1] !== {7'h15, 2'b01}) begin
      errors++; $display("FAIL n2_ids: got %h %h want %h %h",
        mon_q[lb], mon_q[lb+1], {7'h05, 2'b10}, {7'h15, 2'b01});
    end
    checks++;
    if ({done_cnt - db, Proto_err, Ovf_err, Busy} !== {32'd1, 3'b000}) begin
      errors++; $display("FAIL n2_done: got done %0d err %b%b busy %b want 1 00 0",
        done_cnt - db, Proto_err, Ovf_err, Busy);
    end
  endtask

  task automatic test_n5();
    int lb, db;
    logic [8:0] exp_e;
    lb = mon_q.size(); db = done_cnt;
    Nb_ready = 1'b1;
    put(1, 0, 7'd1, 7'd2, 5'd5, 2'd0);
    put(0, 0, 7'd3, 7'd4, 5'd0, 2'd0);
    put(0, 1, 7'd5, 7'h7F, 5'd0, 2'd0);
    idle_in();
    cycles(8);
    checks++;
    if (mon_q.size() - lb !== 5) begin
      errors++; $display("FAIL n5_count: got %0d want 5", mon_q.size() - lb);
    end
    for (int i = 0; i < 5; i++) begin
      exp_e = {7'(i + 1), 1'(i == 0), 1'(i == 4)};
      checks++;
      if (mon_q[lb+i] !== exp_e) begin
        errors++; $display("FAIL n5_id%0d: got %h want %h", i, mon_q[lb+i], exp_e);
      end
    end
    checks++;
    if ({done_cnt - db, Proto_err} !== {32'd1, 1'b0}) begin
      errors++; $display("FAIL n5_done: got %0d/%b want 1/0", done_cnt - db, Proto_err);
    end
  endtask

  task automatic test_trunc();
    int lb, db;
    logic [8:0] exp_e;
    lb = mon_q.size(); db = done_cnt;
    Nb_ready = 1'b1;
    put(1, 0, 7'h10, 7'h11, 5'd3, 2'd0);
    put(0, 0, 7'h12, 7'h13, 5'd0, 2'd0);
    checks++;
    if (Proto_err !== 1'b0) begin
      errors++; $display("FAIL trunc_early: got %b want 0", Proto_err);
    end
    put(0, 1, 7'h14, 7'h15, 5'd0, 2'd0);
    checks++;
    if (Proto_err !== 1'b1) begin
      errors++; $display("FAIL trunc_err: got %b want 1", Proto_err);
    end
    idle_in();
    cycles(8);
    checks++;
    if (mon_q.size() - lb !== 4) begin
      errors++; $display("FAIL trunc_count: got %0d want 4", mon_q.size() - lb);
    end
    for (int i = 0; i < 4; i++) begin
      exp_e = {7'(16 + i), 1'(i == 0), 1'(i == 3)};
      checks++;
      if (mon_q[lb+i] !== exp_e) begin
        errors++; $display("FAIL trunc_id%0d: got %h want %h", i, mon_q[lb+i], exp_e);
      end
    end
    checks++;
    if ({done_cnt - db, Fifo_cnt, Busy} !== {32'd1, 4'd0, 1'b0}) begin
      errors++; $display("FAIL trunc_done: got %0d cnt %0d busy %b want 1 0 0",
        done_cnt - db, Fifo_cnt, Busy);
    end
  endtask

  task automatic test_idle_nonsos();
    do_reset();
    put(0, 0, 7'd1, 7'd2, 5'd0, 2'd0);
    idle_in();
    checks++;
    if ({Proto_err, Nb_valid, Fifo_cnt} !== {1'b1, 1'b0, 4'd0}) begin
      errors++; $display("FAIL idle_nonsos: got %h want %h",
        {Proto_err, Nb_valid, Fifo_cnt}, {1'b1, 1'b0, 4'd0});
    end
  endtask

  task automatic test_n0();
    do_reset();
    Nb_ready = 1'b1;
    put(1, 1, 7'd0, 7'd0, 5'd0, 2'd0);
    idle_in();
    checks++;
    if ({Pkt_done, Fifo_cnt, Nb_valid, Proto_err} !== {1'b1, 4'd0, 2'b00}) begin
      errors++; $display("FAIL n0_pulse: got %h want %h",
        {Pkt_done, Fifo_cnt, Nb_valid, Proto_err}, {1'b1, 4'd0, 2'b00});
    end
    cycles(1);
    checks++;
    if (Pkt_done !== 1'b0) begin
      errors++; $display("FAIL n0_once: got %b want 0", Pkt_done);
    end
  endtask

  task automatic test_back_to_back();
    int lb, db;
    logic [8:0] exp_e;
    lb = mon_q.size(); db = done_cnt;
    Nb_ready = 1'b1;
    put(1, 1, 7'h21, 7'h22, 5'd2, 2'd0);
    put(1, 1, 7'h23, 7'h24, 5'd2, 2'd0);
    idle_in();
    cycles(6);
    checks++;
    if (mon_q.size() - lb !== 4) begin
      errors++; $display("FAIL b2b_count: got %0d want 4", mon_q.size() - lb);
    end
    for (int i = 0; i < 4; i++) begin
      exp_e = {7'(33 + i), 1'(i % 2 == 0), 1'(i % 2 == 1)};
      checks++;
      if (mon_q[lb+i] !== exp_e) begin
        errors++; $display("FAIL b2b_id%0d: got %h want %h", i, mon_q[lb+i], exp_e);
      end
    end
    checks++;
    if ({done_cnt - db, Proto_err} !== {32'd2, 1'b0}) begin
      errors++; $display("FAIL b2b_done: got %0d/%b want 2/0", done_cnt - db, Proto_err);
    end
  endtask

  task automatic test_resync();
    int lb, db;
    logic [8:0] exp_e;
    lb = mon_q.size(); db = done_cnt;
    Nb_ready = 1'b1;
    put(1, 0, 7'h31, 7'h32, 5'd6, 2'd0);
    put(1, 1, 7'h33, 7'h34, 5'd2, 2'd0);
    idle_in();
    checks++;
    if (Proto_err !== 1'b1) begin
      errors++; $display("FAIL resync_err: got %b want 1", Proto_err);
    end
    cycles(6);
    for (int i = 0; i < 4; i++) begin
      exp_e = {7'(49 + i), 1'(i % 2 == 0), 1'(i % 2 == 1)};
      checks++;
      if (mon_q[lb+i] !== exp_e) begin
        errors++; $display("FAIL resync_id%0d: got %h want %h", i, mon_q[lb+i], exp_e);
      end
    end
    checks++;
    if ({mon_q.size() - lb, done_cnt - db} !== {32'd4, 32'd2}) begin
      errors++; $display("FAIL resync_done: got %0d ids %0d done want 4 2",
        mon_q.size() - lb, done_cnt - db);
    end
  endtask

  task automatic test_ovf();
    int lb, db;
    logic [8:0] exp_e;
    do_reset();
    Nb_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      put(k == 0, k == 8, 7'(2 * k), 7'(2 * k + 1), 5'd18, 2'd0);
      if (k == 8) begin
        checks++;
        if ({Fifo_cnt, Ovf_err} !== {4'd8, 1'b0}) begin
          errors++; $display("FAIL ovf_fill: got cnt %0d ovf %b want 8 0",
            Fifo_cnt, Ovf_err);
        end
      end
    end
    idle_in();
    checks++;
    if ({Fifo_cnt, Ovf_err, Proto_err} !== {4'd8, 2'b10}) begin
      errors++; $display("FAIL ovf_drop: got cnt %0d ovf %b perr %b want 8 1 0",
        Fifo_cnt, Ovf_err, Proto_err);
    end
    lb = mon_q.size(); db = done_cnt;
    Nb_ready = 1'b1;
    cycles(20);
    checks++;
    if (mon_q.size() - lb !== 16) begin
      errors++; $display("FAIL ovf_count: got %0d want 16", mon_q.size() - lb);
    end
    for (int i = 0; i < 16; i++) begin
      exp_e = {7'(i), 1'(i == 0), 1'(i == 15)};
      checks++;
      if (mon_q[lb+i] !== exp_e) begin
        errors++; $display("FAIL ovf_id%0d: got %h want %h", i, mon_q[lb+i], exp_e);
      end
    end
    checks++;
    if ({done_cnt - db, Fifo_cnt, Busy, Ovf_err} !== {32'd1, 4'd0, 2'b01}) begin
      errors++; $display("FAIL ovf_end: got done %0d cnt %0d busy %b ovf %b want 1 0 0 1",
        done_cnt - db, Fifo_cnt, Busy, Ovf_err);
    end
  endtask

  task automatic test_reset_mid();
    int lb, db;
    do_reset();
    Nb_ready = 1'b0;
    put(0, 0, 7'd9, 7'd9, 5'd0, 2'd0);
    put(1, 0, 7'h01, 7'h02, 5'd6, 2'd0);
    put(0, 0, 7'h03, 7'h04, 5'd0, 2'd0);
    idle_in();
    checks++;
    if ({Fifo_cnt, Busy, Proto_err} !== {4'd2, 2'b11}) begin
      errors++; $display("FAIL mid_pre: got cnt %0d busy %b perr %b want 2 1 1",
        Fifo_cnt, Busy, Proto_err);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({Nb_valid, Nb_id, Nb_first, Nb_last, Pkt_done, Busy, Proto_err,
         Ovf_err, Fifo_cnt} !== 18'd0) begin
      errors++; $display("FAIL mid_reset: got %h want 0", {Nb_valid, Nb_id,
        Nb_first, Nb_last, Pkt_done, Busy, Proto_err, Ovf_err, Fifo_cnt});
    end
    reset = 1'b0;
    lb = mon_q.size(); db = done_cnt;
    Nb_ready = 1'b1;
    put(1, 1, 7'h2A, 7'h33, 5'd1, 2'd0);
    idle_in();
    cycles(4);
    checks++;
    if ({mon_q.size() - lb, done_cnt - db} !== {32'd1, 32'd1}) begin
      errors++; $display("FAIL mid_n1_count: got %0d ids %0d done want 1 1",
        mon_q.size() - lb, done_cnt - db);
    end
    checks++;
    if (mon_q[lb] !== {7'h2A, 2'b11}) begin
      errors++; $display("FAIL mid_n1_id: got %h want %h", mon_q[lb], {7'h2A, 2'b11});
    end
  endtask

  task automatic test_tag();
    int lb, db, exp_n;
    do_reset();
    Nb_ready = 1'b1;
    lb = mon_q.size(); db = done_cnt;
    put(1, 1, 7'h41, 7'h42, 5'd2, 2'd1);
    idle_in();
    cycles(4);
`ifdef NEIGHBOR_RX_TAG_FILTER_EN
    exp_n = 0;
`else
    exp_n = 2;
`endif
    checks++;
    if (mon_q.size() - lb !== exp_n || Proto_err !== 1'b0) begin
      errors++; $display("FAIL tag_other: got %0d ids perr %b want %0d 0",
        mon_q.size() - lb, Proto_err, exp_n);
    end
    lb = mon_q.size();
    put(1, 1, 7'h43, 7'h44, 5'd2, 2'd2);
    idle_in();
    cycles(4);
    checks++;
    if (mon_q.size() - lb !== 2 || mon_q[lb] !== {7'h43, 2'b10} ||
        mon_q[lb+1] !== {7'h44, 2'b01}) begin
      errors++; $display("FAIL tag_mine: got %0d ids %h %h want 2 %h %h",
        mon_q.size() - lb, mon_q[lb], mon_q[lb+1], {7'h43, 2'b10}, {7'h44, 2'b01});
    end
    checks++;
    if (done_cnt - db !== exp_n / 2 + 1) begin
      errors++; $display("FAIL tag_done: got %0d want %0d", done_cnt - db, exp_n / 2 + 1);
    end
  endtask

  initial begin
    test_reset();
    test_n2();
    test_n5();
    test_trunc();
    test_idle_nonsos();
    test_n0();
    test_back_to_back();
    test_resync();
    test_ovf();
    test_reset_mid();
    test_tag();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neighbor_stream_rx.md
Name: neighbor_stream_rx

Overview:
- Receiving end of the neighbor-bank-to-Edge-PE stream; sits at the input of each Edge PE.
- Accepts the packed neighbor words (sos/eos/valid, two 7-bit IDs per word) that arrive with no backpressure, and buffers them in a word FIFO.
- Unpacks the buffered words into one-ID-per-transfer valid/ready output for the edge datapath.
- Checks framing and reports protocol errors and overflow.

Parameters:
- ID_W, 7, neighbor ID width; a word is 2*ID_W bits.
- NUM_W, 5, width of the Neighbor_num_Iter count field.
- TAG_W, 2, PE tag width.
- MY_TAG, 0, this PE's tag.
- FIFO_DEPTH, 8, word FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- In_valid  in  1  stream word valid
- In_sos  in  1  start of stream
- In_eos  in  1  end of stream
- In_data  in  2*ID_W  [ID_W-1:0] first ID, [2*ID_W-1:ID_W] second ID
- In_PE_tag  in  TAG_W  destination PE
- In_num_Iter  in  NUM_W  neighbor count N of the packet; valid on the sos word
- Nb_ready  in  1  downstream accepts an ID
- Nb_valid  out  1  ID available
- Nb_id  out  ID_W  neighbor ID
- Nb_first  out  1  first ID of the packet
- Nb_last  out  1  last ID of the packet
- Pkt_done  out  1  one-cycle pulse when the last ID is handed off, or when an N=0 packet is accepted
- Busy  out  1  packet open, FIFO non-empty, or unpacker holding data
- Proto_err  out  1  sticky framing error
- Ovf_err  out  1  sticky overflow, word dropped
- Fifo_cnt  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; half-select 0.
- Both error flags are sticky and are cleared only by reset.
- Reset mid-packet discards everything.

Word acceptance:
- A word is eligible when In_valid=1 (and the tag matches, see Optional Feature).
- A packet of N neighbors is carried in W = ceil(N/2) words; W = 1 when N ≤ 2.
- N=0 packet: a single sos+eos word; no FIFO write; Pkt_done pulses the next cycle.
- Odd N: the final word carries only the low ID; its high half is ignored.

Framing FSM:
- IDLE + sos word:
  - Capture N; clear the word counter wc.
  - Push the word; wc=1.
  - If eos is also set: check W==1; stay IDLE.
  - Otherwise go to RECV.
- IDLE + word without sos: drop the word, set Proto_err.
- RECV + word without sos:
  - Push the word; wc++.
  - If eos: set Proto_err if wc+1 ≠ W; go to IDLE.
  - If not eos and wc+1 == W: set Proto_err, force packet end (mark the word last), go to IDLE. Words arriving after this are treated as IDLE words.
- RECV + sos: set Proto_err; the open packet is closed by marking its last FIFO entry as last (ID count truncated); start the new packet as from IDLE.
- A pushed FIFO entry is {data, first, last, single_low}:
  - single_low = last word of an odd-N packet.
  - A forced-truncated entry has single_low=0.

FIFO:
- Registered, show-ahead.
- A word accepted at edge t can drive Nb_valid in the cycle after edge t.
- Push while full is allowed only if the head entry is fully popped in the same cycle. Otherwise the word is dropped and Ovf_err is set.
  - If the dropped word is sos/eos, framing state still updates as if the word had been pushed.

Unpacker:
- Head entry with half-select h=0 → Nb_id = low ID; with h=1 → Nb_id = high ID.
- Nb_first = entry.first & h==0.
- Nb_last = entry.last & (h==1 | single_low).
- On a Nb_valid & Nb_ready transfer:
  - If h==0 & !single_low: h←1.
  - Otherwise pop the entry, h←0.
- Pkt_done pulses in the cycle after a transfer with Nb_last=1.
- Nb_valid = FIFO non-empty; it does not depend on Nb_ready.
- Outputs hold stable while Nb_valid=1 & Nb_ready=0.

Arithmetic:
- wc is NUM_W bits.
- W is computed as (N+1)>>1 with a NUM_W+1-bit intermediate, so N = 2^NUM_W−1 does not wrap.

Optional Feature:
- Macro: NEIGHBOR_RX_TAG_FILTER_EN.
- Defined: a word is eligible only if In_PE_tag == MY_TAG. Non-matching words are ignored entirely (no error, no FSM effect).
- Undefined: the tag is ignored; every valid word is eligible.

Test Plan:
- N=2, one sos+eos word 0x0A85 (IDs 0x05, 0x15), Nb_ready=1:
  - Nb_id 0x05 with first=1, then 0x15 with last=1.
  - Pkt_done the following cycle; no errors.
- N=5, three words (sos; mid; eos with high half 0x7F):
  - Exactly 5 IDs in order; only the 5th has Nb_last.
  - 0x7F is never output.
- N=3 packet whose eos arrives on the 3rd word:
  - Proto_err=1 at the 2nd word (wc==W forces the end).
  - The 3rd word is treated as an IDLE non-sos word: dropped.
- Nb_ready=0 while FIFO_DEPTH+1 words of an N=18 packet stream in:
  - Fifo_cnt saturates at 8; Ovf_err=1; the 9th word is dropped.
  - After Nb_ready=1: 16 IDs drain, the last one has Nb_last=1.
- Reset asserted mid-packet: next cycle all outputs are 0, Fifo_cnt=0; a following N=1 packet yields a single ID with first=last=1.
- With NEIGHBOR_RX_TAG_FILTER_EN and MY_TAG=2: tag-1 packets produce no output and no errors; tag-2 packets are received normally.
